// File: rtl/wallace_mult_arbiter.sv
// rtl/wallace_mult_arbiter.sv - round-robin sharing of one external 32x32 multiplier
//
// Purpose: accepts operand pairs from NREQ requesters over valid/ready channels,
// registers the round-robin winner onto mul_a/mul_b (stage S1), captures the
// combinational product mul_p into a tagged response register (stage S2) that
// holds under backpressure, and counts completed response handshakes.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_valid/ready   per-requester handshake, one bit per requester
//   req_a/req_b       packed operands, requester i at [32*i+31:32*i]
//   mul_a/mul_b       registered operands driven into the multiplier
//   mul_p             64-bit unsigned product returned by the multiplier
//   rsp_valid/ready   response handshake
//   rsp_p/rsp_id      product and the index of the requester that issued it
//   done_cnt          completed response handshakes, wrapping modulo 2^32
module wallace_mult_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [31:0]        mul_a,
  output logic [31:0]        mul_b,
  input  logic [63:0]        mul_p,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [63:0]        rsp_p,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        done_cnt
);

  logic            s1_valid;
  logic [IDW-1:0]  s1_id;
  logic [IDW-1:0]  ptr;

  logic            s2_adv;
  logic            s1_adv;

  logic            grant_found;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  grant_nxt_ptr;
  logic [NREQ-1:0] grant_vec;
  logic [31:0]     grant_a;
  logic [31:0]     grant_b;
  logic            grant;

  // S1 only stalls when it is occupied and S2 cannot take its entry, so an
  // empty S1 accepts regardless of what the response side is doing.
  assign s2_adv = !rsp_valid || rsp_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // Round-robin search: start at ptr, ascending, wrap at NREQ-1 back to 0.
  always_comb begin : arb
    int idx;
    grant_found   = 1'b0;
    grant_id      = '0;
    grant_nxt_ptr = '0;
    grant_vec     = '0;
    grant_a       = '0;
    grant_b       = '0;
    idx           = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!grant_found && req_valid[idx]) begin
        grant_found    = 1'b1;
        grant_id       = IDW'(idx);
        grant_nxt_ptr  = (idx == NREQ - 1) ? '0 : IDW'(idx + 1);
        grant_vec[idx] = 1'b1;
        grant_a        = req_a[idx*32 +: 32];
        grant_b        = req_b[idx*32 +: 32];
      end
    end
  end

  assign req_ready = (s1_adv && !rst) ? grant_vec : '0;
  assign grant     = grant_found && s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      ptr       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= '0;
      done_cnt  <= '0;
    end else begin
      // S1: load the winner, or go empty while keeping the last operands so
      // the multiplier inputs do not toggle needlessly.
      if (s1_adv) begin
        if (grant) begin
          s1_valid <= 1'b1;
          s1_id    <= grant_id;
          mul_a    <= grant_a;
          mul_b    <= grant_b;
          ptr      <= grant_nxt_ptr;
        end else begin
          s1_valid <= 1'b0;
        end
      end

      // S2: product is sampled one cycle after the operands were registered.
      if (s2_adv) begin
        rsp_valid <= s1_valid;
        if (s1_valid) begin
          rsp_p  <= mul_p;
          rsp_id <= s1_id;
        end
      end

      if (rsp_valid && rsp_ready) begin
        done_cnt <= done_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_wallace_mult_arbiter.sv
// tb/tb_wallace_mult_arbiter.sv - self-checking bench for wallace_mult_arbiter
module tb_wallace_mult_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [31:0]        mul_a;
  logic [31:0]        mul_b;
  logic [63:0]        mul_p;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [63:0]        rsp_p;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        done_cnt;

  always #5 clk = ~clk;

  // Stand-in for the external combinational multiplier.
  assign mul_p = {32'd0, mul_a} * {32'd0, mul_b};

  wallace_mult_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .done_cnt  (done_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [63:0]    p;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every response handshake must match the oldest expected entry.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_p", rsp_p, mon_e.p);
        check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic push(input logic [63:0] p, input int id);
    exp_t e;
    e.p  = p;
    e.id = IDW'(id);
    sb.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    rsp_ready = 1'b1;
    while (sb.size() != 0 && t < 50) begin
      cyc();
      t++;
    end
    check("drain_pending", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{id: 1, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, p: 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{id: 2, a: 32'h0,         b: 32'h1234_5678, p: 64'h0};
    vecs[2] = '{id: 0, a: 32'd7,         b: 32'd6,         p: 64'd42};
    vecs[3] = '{id: 3, a: 32'h8000_0000, b: 32'd2,         p: 64'h1_0000_0000};

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    cyc(); cyc();
    req_valid = 4'b0001;
    cyc();

    // Reset state, with a request present to show req_ready is held low.
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_p", rsp_p, 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_done_cnt", 64'(done_cnt), 64'd0);

    // Single request: 3*5 with latency check.
    cyc();
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_ops(0, 32'd3, 32'd5);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t1_grant", 64'(req_ready), 64'h1);
    push(64'd15, 0);
    cyc();
    req_valid = '0;
    @(negedge clk);
    check("t1_mul_a", 64'(mul_a), 64'd3);
    check("t1_rsp_valid_early", 64'(rsp_valid), 64'd0);
    check("t1_ready_after", 64'(req_ready), 64'd0);
    cyc();
    @(negedge clk);
    check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    cyc();
    @(negedge clk);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_rsp_idle", 64'(rsp_valid), 64'd0);

    // Table of single-requester vectors, including full-width corners.
    for (int v = 0; v < 4; v++) begin
      cyc();
      set_ops(vecs[v].id, vecs[v].a, vecs[v].b);
      req_valid = '0;
      req_valid[vecs[v].id] = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_grant", v), 64'(req_ready), 64'(1) << vecs[v].id);
      push(vecs[v].p, vecs[v].id);
      cyc();
      req_valid = '0;
    end
    drain();

    // Pointer is 0 after the grant to 3; 2 and 3 both request.
    cyc();
    set_ops(2, 32'd2, 32'd2);
    set_ops(3, 32'd3, 32'd3);
    req_valid = 4'b1100;
    @(negedge clk);
    check("wrap_first", 64'(req_ready), 64'b0100);
    push(64'd4, 2);
    cyc();
    req_valid = 4'b1000;
    @(negedge clk);
    check("wrap_second", 64'(req_ready), 64'b1000);
    push(64'd9, 3);
    cyc();
    req_valid = '0;
    drain();

    // All requesters valid: strict rotation, one response per cycle.
    cyc();
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i + 1), 32'd10);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rot%0d_grant", k), 64'(req_ready), 64'(1) << (k % 4));
      if (k >= 2) check($sformatf("rot%0d_rsp_valid", k), 64'(rsp_valid), 64'd1);
      push(64'(10 * (k % 4 + 1)), k % 4);
      cyc();
    end
    req_valid = '0;
    drain();
    check("pre_bp_done_cnt", 64'(done_cnt), 64'd13);

    // Backpressure: pointer is 2; three requests while the consumer stalls.
    cyc();
    rsp_ready = 1'b0;
    set_ops(2, 32'd100, 32'd3);
    set_ops(3, 32'd200, 32'd3);
    set_ops(0, 32'd300, 32'd3);
    req_valid = 4'b0100;
    @(negedge clk);
    check("bp_grant0", 64'(req_ready), 64'b0100);
    push(64'd300, 2);
    cyc();
    req_valid = 4'b1000;
    @(negedge clk);
    check("bp_grant1", 64'(req_ready), 64'b1000);
    push(64'd600, 3);
    cyc();
    req_valid = 4'b0001;
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_ready", h), 64'(req_ready), 64'd0);
      check($sformatf("bp_hold%0d_valid", h), 64'(rsp_valid), 64'd1);
      check($sformatf("bp_hold%0d_p", h), rsp_p, 64'd300);
      check($sformatf("bp_hold%0d_id", h), 64'(rsp_id), 64'd2);
      check($sformatf("bp_hold%0d_mul_a", h), 64'(mul_a), 64'd200);
      cyc();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_grant2", 64'(req_ready), 64'b0001);
    push(64'd900, 0);
    cyc();
    req_valid = '0;
    drain();
    check("bp_done_cnt", 64'(done_cnt), 64'd16);

    // Reset with two operations in flight; pointer is 1 beforehand.
    cyc();
    rsp_ready = 1'b0;
    set_ops(1, 32'd5, 32'd5);
    set_ops(2, 32'd6, 32'd6);
    req_valid = 4'b0010;
    @(negedge clk);
    check("rr_grant0", 64'(req_ready), 64'b0010);
    cyc();
    req_valid = 4'b0100;
    @(negedge clk);
    check("rr_grant1", 64'(req_ready), 64'b0100);
    cyc();
    req_valid = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rr_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rr_done_cnt", 64'(done_cnt), 64'd0);
    check("rr_mul_a", 64'(mul_a), 64'd0);
    cyc();
    @(negedge clk);
    check("rr_no_rsp", 64'(rsp_valid), 64'd0);
    // Pointer restarts at 0: 0 beats 3 (a stale pointer of 3 would pick 3).
    cyc();
    set_ops(0, 32'd7, 32'd6);
    set_ops(3, 32'd2, 32'd2);
    req_valid = 4'b1001;
    @(negedge clk);
    check("rr_ptr0_grant", 64'(req_ready), 64'b0001);
    push(64'd42, 0);
    cyc();
    req_valid = 4'b1000;
    @(negedge clk);
    check("rr_next_grant", 64'(req_ready), 64'b1000);
    push(64'd4, 3);
    cyc();
    req_valid = '0;
    drain();
    check("rr_done_cnt_end", 64'(done_cnt), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
